// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32IM decode types, control word, buffer entry and M-op table
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    // funct3 is copied into cmpop by default, so every encoding needs a name.
    typedef enum logic [2:0] {
        br_beq  = 3'b000,
        br_bne  = 3'b001,
        br_rsv2 = 3'b010,
        br_rsv3 = 3'b011,
        br_blt  = 3'b100,
        br_bge  = 3'b101,
        br_bltu = 3'b110,
        br_bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        ar_add  = 3'b000,
        ar_sll  = 3'b001,
        ar_slt  = 3'b010,
        ar_sltu = 3'b011,
        ar_xor  = 3'b100,
        ar_sr   = 3'b101,
        ar_or   = 3'b110,
        ar_and  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        ld_lb  = 3'b000,
        ld_lh  = 3'b001,
        ld_lw  = 3'b010,
        ld_lbu = 3'b100,
        ld_lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [3:0] {
        rf_alu_out  = 4'd0,
        rf_br_en    = 4'd1,
        rf_u_imm    = 4'd2,
        rf_lw       = 4'd3,
        rf_pc_plus4 = 4'd4,
        rf_lb       = 4'd5,
        rf_lbu      = 4'd6,
        rf_lh       = 4'd7,
        rf_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef enum logic {
        alu1_rs1_out = 1'b0,
        alu1_pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alu2_i_imm   = 3'd0,
        alu2_u_imm   = 3'd1,
        alu2_b_imm   = 3'd2,
        alu2_s_imm   = 3'd3,
        alu2_j_imm   = 3'd4,
        alu2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic {
        cmp_rs2_out = 1'b0,
        cmp_i_imm   = 1'b1
    } cmpmux_sel_t;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // All-zero is the "do nothing" word: alu_out, rs1_out, i_imm, rs2_out, no writes.
    typedef struct packed {
        alu_ops          aluop;
        regfilemux_sel_t regfilemux_sel;
        logic            load_regfile;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        branch_funct3_t  cmpop;
        cmpmux_sel_t     cmpmux_sel;
        logic            mem_read;
        logic            mem_write;
        logic            br_sel;
        logic            arith_mux_sel;
        logic [1:0]      muldiv_mask;
        logic            su_op1;
        logic            su_op2;
        logic [1:0]      muldiv_mux_sel;
        logic            divsign;
    } rv32i_control_word;

    // muldiv_mask: 01 multiplier, 10 divider.
    // su_op1/su_op2: operand is treated as signed.
    // muldiv_mux_sel: 0 product low, 1 product high, 2 quotient, 3 remainder.
    // divsign: signed division.
    typedef struct packed {
        logic [1:0] muldiv_mask;
        logic       su_op1;
        logic       su_op2;
        logic [1:0] muldiv_mux_sel;
        logic       divsign;
    } m_op_t;

    localparam m_op_t M_OP_TABLE [0:7] = '{
        '{2'b01, 1'b1, 1'b1, 2'd0, 1'b0},  // mul
        '{2'b01, 1'b1, 1'b1, 2'd1, 1'b0},  // mulh
        '{2'b01, 1'b1, 1'b0, 2'd1, 1'b0},  // mulhsu
        '{2'b01, 1'b0, 1'b0, 2'd1, 1'b0},  // mulhu
        '{2'b10, 1'b1, 1'b1, 2'd2, 1'b1},  // div
        '{2'b10, 1'b0, 1'b0, 2'd2, 1'b0},  // divu
        '{2'b10, 1'b1, 1'b1, 2'd3, 1'b1},  // rem
        '{2'b10, 1'b0, 1'b0, 2'd3, 1'b0}   // remu
    };

    function automatic m_op_t m_op_lookup(input logic [2:0] funct3);
        return M_OP_TABLE[funct3];
    endfunction

    typedef struct packed {
        rv32i_control_word ctrl;
        logic              illegal;
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic              lane_valid;
    } decode_lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } dec_state_t;

endpackage

// File: rtl/decode_lane.sv
// rtl/decode_lane.sv - combinational single-instruction RV32I(M) decoder
//   instr_i   : 32-bit instruction word
//   ctrl_o    : decoded control word, '0 when the encoding is illegal
//   illegal_o : encoding is not a supported instruction
module decode_lane
    import rv32i_types::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0]       instr_i,
    output rv32i_control_word ctrl_o,
    output logic              illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       sig_unused;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    // Register specifiers are routed elsewhere; decode never looks at them.
    assign sig_unused = ^{instr_i[24:15], instr_i[11:7]};

    rv32i_control_word ctrl_d;
    logic              illegal_d;
    m_op_t             m_op;

    always_comb begin
        ctrl_d       = '0;
        illegal_d    = 1'b0;
        m_op         = m_op_lookup(funct3);
        ctrl_d.aluop = alu_ops'(funct3);
        ctrl_d.cmpop = branch_funct3_t'(funct3);

        case (opcode)
            op_lui: begin
                ctrl_d.load_regfile   = 1'b1;
                ctrl_d.regfilemux_sel = rf_u_imm;
            end
            op_auipc: begin
                ctrl_d.aluop        = alu_add;
                ctrl_d.alumux1_sel  = alu1_pc_out;
                ctrl_d.alumux2_sel  = alu2_u_imm;
                ctrl_d.load_regfile = 1'b1;
            end
            op_jal: begin
                ctrl_d.aluop          = alu_add;
                ctrl_d.alumux1_sel    = alu1_pc_out;
                ctrl_d.alumux2_sel    = alu2_j_imm;
                ctrl_d.regfilemux_sel = rf_pc_plus4;
                ctrl_d.load_regfile   = 1'b1;
                ctrl_d.br_sel         = 1'b1;
            end
            op_jalr: begin
                ctrl_d.aluop          = alu_add;
                ctrl_d.regfilemux_sel = rf_pc_plus4;
                ctrl_d.load_regfile   = 1'b1;
                ctrl_d.br_sel         = 1'b1;
                if (funct3 != 3'b000) illegal_d = 1'b1;
            end
            op_br: begin
                ctrl_d.aluop       = alu_add;
                ctrl_d.alumux1_sel = alu1_pc_out;
                ctrl_d.alumux2_sel = alu2_b_imm;
                ctrl_d.br_sel      = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011) illegal_d = 1'b1;
            end
            op_load: begin
                ctrl_d.aluop        = alu_add;
                ctrl_d.mem_read     = 1'b1;
                ctrl_d.load_regfile = 1'b1;
                case (funct3)
                    ld_lb:   ctrl_d.regfilemux_sel = rf_lb;
                    ld_lh:   ctrl_d.regfilemux_sel = rf_lh;
                    ld_lw:   ctrl_d.regfilemux_sel = rf_lw;
                    ld_lbu:  ctrl_d.regfilemux_sel = rf_lbu;
                    ld_lhu:  ctrl_d.regfilemux_sel = rf_lhu;
                    default: illegal_d = 1'b1;
                endcase
            end
            op_store: begin
                ctrl_d.aluop       = alu_add;
                ctrl_d.alumux2_sel = alu2_s_imm;
                ctrl_d.mem_write   = 1'b1;
                if (funct3 > 3'd2) illegal_d = 1'b1;
            end
            op_imm: begin
                ctrl_d.load_regfile = 1'b1;
                case (funct3)
                    ar_slt: begin
                        ctrl_d.regfilemux_sel = rf_br_en;
                        ctrl_d.cmpop          = br_blt;
                        ctrl_d.cmpmux_sel     = cmp_i_imm;
                    end
                    ar_sltu: begin
                        ctrl_d.regfilemux_sel = rf_br_en;
                        ctrl_d.cmpop          = br_bltu;
                        ctrl_d.cmpmux_sel     = cmp_i_imm;
                    end
                    ar_sll: begin
                        if (funct7 != F7_BASE) illegal_d = 1'b1;
                    end
                    ar_sr: begin
                        ctrl_d.aluop = funct7[5] ? alu_sra : alu_srl;
                        if (funct7 != F7_BASE && funct7 != F7_ALT) illegal_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            op_reg: begin
                ctrl_d.alumux2_sel  = alu2_rs2_out;
                ctrl_d.load_regfile = 1'b1;
                if (funct7 == F7_MULDIV) begin
                    if (!EN_M) begin
                        illegal_d = 1'b1;
                    end else begin
                        ctrl_d.arith_mux_sel  = 1'b1;
                        ctrl_d.muldiv_mask    = m_op.muldiv_mask;
                        ctrl_d.su_op1         = m_op.su_op1;
                        ctrl_d.su_op2         = m_op.su_op2;
                        ctrl_d.muldiv_mux_sel = m_op.muldiv_mux_sel;
                        ctrl_d.divsign        = m_op.divsign;
                    end
                end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    // Only add/sub and srl/sra have an alternate (0x20) form.
                    if (funct7 == F7_ALT && funct3 != ar_add && funct3 != ar_sr)
                        illegal_d = 1'b1;
                    case (funct3)
                        ar_add: ctrl_d.aluop = funct7[5] ? alu_sub : alu_add;
                        ar_sr:  ctrl_d.aluop = funct7[5] ? alu_sra : alu_srl;
                        ar_slt: begin
                            ctrl_d.regfilemux_sel = rf_br_en;
                            ctrl_d.cmpop          = br_blt;
                        end
                        ar_sltu: begin
                            ctrl_d.regfilemux_sel = rf_br_en;
                            ctrl_d.cmpop          = br_bltu;
                        end
                        default: ;
                    endcase
                end else begin
                    illegal_d = 1'b1;
                end
            end
            default: illegal_d = 1'b1;
        endcase

        // Compressed or reserved-length encodings never match a base opcode.
        if (instr_i[1:0] != 2'b11) illegal_d = 1'b1;
    end

    assign ctrl_o    = illegal_d ? '0 : ctrl_d;
    assign illegal_o = illegal_d;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered multi-lane decode stage with two-entry skid buffer
//   clk, rst                 : clock, synchronous active-high reset
//   flush                    : drop everything buffered and arriving
//   in_valid/in_ready        : input bundle handshake (in_ready is a flop)
//   in_lane_valid/instr/pc   : per-lane input bundle
//   out_valid/out_ready      : output bundle handshake
//   out_lane_valid/ctrl/illegal/pc/instr : per-lane decoded bundle
module decode_stage
    import rv32i_types::*;
#(
    parameter int LANES = 1,
    parameter bit EN_M  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_lane_valid,
    input  logic [LANES-1:0][31:0]        in_instr,
    input  logic [LANES-1:0][31:0]        in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_lane_valid,
    output rv32i_control_word [LANES-1:0] out_ctrl,
    output logic [LANES-1:0]              out_illegal,
    output logic [LANES-1:0][31:0]        out_pc,
    output logic [LANES-1:0][31:0]        out_instr
);

    decode_lane_t [LANES-1:0] lanes_d;
    decode_lane_t [LANES-1:0] m_q;
    decode_lane_t [LANES-1:0] s_q;
    dec_state_t               state_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     accept;
    logic                     pop;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rv32i_control_word lane_ctrl;
        logic              lane_illegal;

        decode_lane #(
            .EN_M(EN_M)
        ) u_decode_lane (
            .instr_i   (in_instr[g]),
            .ctrl_o    (lane_ctrl),
            .illegal_o (lane_illegal)
        );

        // An empty lane carries no operation and is never reported illegal.
        assign lanes_d[g] = '{
            ctrl:       in_lane_valid[g] ? lane_ctrl : '0,
            illegal:    in_lane_valid[g] & lane_illegal,
            pc:         in_pc[g],
            instr:      in_instr[g],
            lane_valid: in_lane_valid[g]
        };

        assign out_ctrl[g]       = m_q[g].ctrl;
        assign out_illegal[g]    = m_q[g].illegal;
        assign out_pc[g]         = m_q[g].pc;
        assign out_instr[g]      = m_q[g].instr;
        assign out_lane_valid[g] = m_q[g].lane_valid;
    end

    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    // in_ready_q/out_valid_q are kept as flops beside the state so neither
    // output has logic behind it, and out_ready never reaches in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_q         <= '0;
            s_q         <= '0;
        end else if (flush) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        m_q         <= lanes_d;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_q <= lanes_d;
                    end else if (accept) begin
                        s_q        <= lanes_d;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        m_q        <= s_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (2-lane M-enabled and 1-lane M-disabled)
module tb_decode_stage;
    import rv32i_types::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic [1:0]             in_lane_valid = '0;
    logic [1:0][31:0]       in_instr = '0;
    logic [1:0][31:0]       in_pc = '0;

    logic                   in_ready, out_valid;
    logic [1:0]             out_lane_valid, out_illegal;
    rv32i_control_word [1:0] out_ctrl;
    logic [1:0][31:0]       out_pc, out_instr;

    logic                   d1_in_ready, d1_out_valid;
    logic [0:0]             d1_lane_valid, d1_illegal;
    rv32i_control_word [0:0] d1_ctrl;
    logic [0:0][31:0]       d1_pc, d1_instr;

    int n_checks = 0;
    int n_err    = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    decode_stage #(.LANES(2), .EN_M(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_ctrl(out_ctrl),
        .out_illegal(out_illegal), .out_pc(out_pc), .out_instr(out_instr)
    );

    decode_stage #(.LANES(1), .EN_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d1_in_ready),
        .in_lane_valid(in_lane_valid[0]), .in_instr(in_instr[0]), .in_pc(in_pc[0]),
        .out_valid(d1_out_valid), .out_ready(out_ready),
        .out_lane_valid(d1_lane_valid), .out_ctrl(d1_ctrl),
        .out_illegal(d1_illegal), .out_pc(d1_pc), .out_instr(d1_instr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction-level decode rules, written from the ISA view.
    function automatic void exp_decode(input logic [31:0] w, input bit en_m,
                                       output rv32i_control_word c, output bit ill);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        c = '0; ill = 1'b0;
        c.aluop = alu_ops'(f3);
        c.cmpop = branch_funct3_t'(f3);
        if (op == 7'h37) begin
            c.load_regfile = 1; c.regfilemux_sel = rf_u_imm;
        end else if (op == 7'h17) begin
            c.aluop = alu_add; c.alumux1_sel = alu1_pc_out; c.alumux2_sel = alu2_u_imm;
            c.load_regfile = 1;
        end else if (op == 7'h6F) begin
            c.aluop = alu_add; c.alumux1_sel = alu1_pc_out; c.alumux2_sel = alu2_j_imm;
            c.regfilemux_sel = rf_pc_plus4; c.load_regfile = 1; c.br_sel = 1;
        end else if (op == 7'h67) begin
            c.aluop = alu_add; c.regfilemux_sel = rf_pc_plus4; c.load_regfile = 1; c.br_sel = 1;
            ill = (f3 != 0);
        end else if (op == 7'h63) begin
            c.aluop = alu_add; c.alumux1_sel = alu1_pc_out; c.alumux2_sel = alu2_b_imm; c.br_sel = 1;
            ill = (f3 == 2 || f3 == 3);
        end else if (op == 7'h03) begin
            c.aluop = alu_add; c.mem_read = 1; c.load_regfile = 1;
            if (f3 == 0) c.regfilemux_sel = rf_lb;
            else if (f3 == 1) c.regfilemux_sel = rf_lh;
            else if (f3 == 2) c.regfilemux_sel = rf_lw;
            else if (f3 == 4) c.regfilemux_sel = rf_lbu;
            else if (f3 == 5) c.regfilemux_sel = rf_lhu;
            else ill = 1;
        end else if (op == 7'h23) begin
            c.aluop = alu_add; c.alumux2_sel = alu2_s_imm; c.mem_write = 1;
            ill = (f3 > 2);
        end else if (op == 7'h13) begin
            c.load_regfile = 1;
            if (f3 == 2 || f3 == 3) begin
                c.regfilemux_sel = rf_br_en; c.cmpmux_sel = cmp_i_imm;
                c.cmpop = (f3 == 2) ? br_blt : br_bltu;
            end else if (f3 == 1) begin
                ill = (f7 != 0);
            end else if (f3 == 5) begin
                if (f7 == 7'h20) c.aluop = alu_sra;
                else if (f7 == 7'h00) c.aluop = alu_srl;
                else ill = 1;
            end
        end else if (op == 7'h33) begin
            c.load_regfile = 1; c.alumux2_sel = alu2_rs2_out;
            if (f7 == 7'h01) begin
                if (!en_m) ill = 1;
                else begin
                    c.arith_mux_sel  = 1;
                    c.muldiv_mask    = (f3 < 4) ? 2'b01 : 2'b10;
                    c.su_op1         = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 6);
                    c.su_op2         = (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 6);
                    c.muldiv_mux_sel = (f3 == 0) ? 2'd0 : (f3 < 4) ? 2'd1 : (f3 < 6) ? 2'd2 : 2'd3;
                    c.divsign        = (f3 == 4 || f3 == 6);
                end
            end else if (f7 == 7'h00 || f7 == 7'h20) begin
                if (f7 == 7'h20 && !(f3 == 0 || f3 == 5)) ill = 1;
                if (f3 == 0) c.aluop = (f7 == 7'h20) ? alu_sub : alu_add;
                if (f3 == 5) c.aluop = (f7 == 7'h20) ? alu_sra : alu_srl;
                if (f3 == 2 || f3 == 3) begin
                    c.regfilemux_sel = rf_br_en;
                    c.cmpop = (f3 == 2) ? br_blt : br_bltu;
                end
            end else ill = 1;
        end else begin
            ill = 1;
        end
        if (ill) c = '0;
    endfunction

    typedef struct {
        logic [1:0]       lv;
        logic [1:0][31:0] ins;
        logic [1:0][31:0] pc;
    } bundle_t;
    bundle_t q[$];

    // Scoreboard: the buffer is a FIFO of at most two accepted bundles.
    always @(negedge clk) begin
        if (started) begin
            rv32i_control_word c;
            bit il, exp_valid, acc, pop_e;
            bundle_t b;
            exp_valid = (q.size() != 0);
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("d1_out_valid", 64'(d1_out_valid), 64'(exp_valid));
            chk("d1_in_ready", 64'(d1_in_ready), 64'(q.size() < 2));
            if (exp_valid) begin
                b = q[0];
                chk("lane_valid", 64'(out_lane_valid), 64'(b.lv));
                for (int l = 0; l < 2; l++) begin
                    exp_decode(b.ins[l], 1'b1, c, il);
                    if (!b.lv[l]) begin c = '0; il = 1'b0; end
                    chk($sformatf("ctrl[%0d] pc=%h", l, b.pc[l]), 64'(out_ctrl[l]), 64'(c));
                    chk($sformatf("illegal[%0d]", l), 64'(out_illegal[l]), 64'(il));
                    chk($sformatf("pc[%0d]", l), 64'(out_pc[l]), 64'(b.pc[l]));
                    chk($sformatf("instr[%0d]", l), 64'(out_instr[l]), 64'(b.ins[l]));
                end
                exp_decode(b.ins[0], 1'b0, c, il);
                chk("d1_ctrl", 64'(d1_ctrl[0]), 64'(c));
                chk("d1_illegal", 64'(d1_illegal[0]), 64'(il));
                chk("d1_pc", 64'(d1_pc[0]), 64'(b.pc[0]));
            end
            acc   = in_valid && (q.size() < 2);
            pop_e = exp_valid && out_ready;
            if (rst || flush) begin
                q.delete();
            end else begin
                if (pop_e) void'(q.pop_front());
                if (acc) begin
                    b.lv = in_lane_valid; b.ins = in_instr; b.pc = in_pc;
                    q.push_back(b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1);
        in_valid = 1'b1; in_lane_valid = lv;
        in_instr[0] = i0; in_pc[0] = p0; in_instr[1] = i1; in_pc[1] = p1;
    endtask

    task automatic send(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] p0,
                        input logic [31:0] i1, input logic [31:0] p1);
        bit acc;
        int n;
        n = 0;
        drive(lv, i0, p0, i1, p1);
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            n_checks++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles required accept", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
        chk({tag, "_pc"}, 64'(out_pc), 64'd0);
        chk({tag, "_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_lane_valid"}, 64'(out_lane_valid), 64'd0);
        chk({tag, "_illegal"}, 64'(out_illegal), 64'd0);
        chk({tag, "_d1_ctrl"}, 64'(d1_ctrl), 64'd0);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] SUB  = 32'h402080B3;
    localparam logic [31:0] MUL  = 32'h02208033;
    localparam logic [31:0] ALL1 = 32'hFFFFFFFF;
    localparam logic [31:0] LW3  = 32'h0000B083;
    localparam logic [31:0] SLLI_BAD = 32'h40109093;

    logic [20:0] tab [0:27] = '{
        {7'h12, 3'd5, 7'h37}, {7'h00, 3'd0, 7'h17}, {7'h00, 3'd0, 7'h6F}, {7'h00, 3'd0, 7'h67},
        {7'h00, 3'd1, 7'h67}, {7'h00, 3'd1, 7'h63}, {7'h00, 3'd6, 7'h63}, {7'h00, 3'd2, 7'h63},
        {7'h00, 3'd0, 7'h03}, {7'h00, 3'd5, 7'h03}, {7'h00, 3'd6, 7'h03}, {7'h00, 3'd2, 7'h23},
        {7'h00, 3'd3, 7'h23}, {7'h00, 3'd2, 7'h13}, {7'h00, 3'd3, 7'h13}, {7'h20, 3'd5, 7'h13},
        {7'h00, 3'd5, 7'h13}, {7'h10, 3'd5, 7'h13}, {7'h7F, 3'd4, 7'h13}, {7'h00, 3'd2, 7'h33},
        {7'h00, 3'd3, 7'h33}, {7'h20, 3'd5, 7'h33}, {7'h20, 3'd7, 7'h33}, {7'h02, 3'd0, 7'h33},
        {7'h01, 3'd5, 7'h33}, {7'h01, 3'd7, 7'h33}, {7'h00, 3'd0, 7'h12}, {7'h00, 3'd0, 7'h73}
    };

    initial begin
        rv32i_control_word c, c_lit;
        bit il;

        // Pin the model against hand-derived words.
        exp_decode(ADDI, 1'b1, c, il);
        c_lit = '0; c_lit.load_regfile = 1'b1;
        chk("model_addi", 64'(c), 64'(c_lit));
        exp_decode(SUB, 1'b1, c, il);
        chk("model_sub_aluop", 64'(c.aluop), 64'(3'b011));
        exp_decode(MUL, 1'b0, c, il);
        chk("model_mul_nom_illegal", 64'(il), 64'd1);

        // Reset
        step(); step();
        started = 1'b1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Basic decode and latency
        out_ready = 1'b1;
        drive(2'b01, ADDI, 32'h100, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_load_regfile", 64'(out_ctrl[0].load_regfile), 64'd1);
        chk("addi_alumux2", 64'(out_ctrl[0].alumux2_sel), 64'(alu2_i_imm));
        chk("addi_illegal", 64'(out_illegal[0]), 64'd0);
        step();

        // Backpressure
        out_ready = 1'b0;
        drive(2'b11, mk(7'h00, 3'd2, 7'h03), 32'h200, mk(7'h00, 3'd0, 7'h37), 32'h204);
        step();
        chk("bp_one_ready", 64'(in_ready), 64'd1);
        drive(2'b11, mk(7'h00, 3'd0, 7'h63), 32'h208, mk(7'h00, 3'd1, 7'h23), 32'h20C);
        step();
        chk("bp_two_ready", 64'(in_ready), 64'd0);
        drive(2'b11, mk(7'h00, 3'd0, 7'h6F), 32'h210, mk(7'h20, 3'd5, 7'h13), 32'h214);
        step();
        chk("bp_stall_pc", 64'(out_pc[0]), 64'h200);
        out_ready = 1'b1;
        step();
        chk("bp_drain1_pc", 64'(out_pc[0]), 64'h208);
        step();
        chk("bp_drain2_pc", 64'(out_pc[0]), 64'h210);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Illegal encodings
        send(2'b11, ALL1, 32'h300, LW3, 32'h304);
        chk("ill_both", 64'(out_illegal), 64'h3);
        chk("ill_ctrl", 64'(out_ctrl), 64'd0);
        send(2'b11, SLLI_BAD, 32'h308, ADDI, 32'h30C);
        chk("ill_slli", 64'(out_illegal), 64'h1);
        chk("ill_slli_ctrl", 64'(out_ctrl[0]), 64'd0);
        send(2'b01, MUL, 32'h310, 32'h0, 32'h0);
        chk("mul_arith_sel", 64'(out_ctrl[0].arith_mux_sel), 64'd1);
        chk("mul_legal", 64'(out_illegal[0]), 64'd0);
        chk("mul_nom_illegal", 64'(d1_illegal[0]), 64'd1);
        chk("mul_nom_ctrl", 64'(d1_ctrl[0]), 64'd0);

        // Two lanes, lane1 empty
        send(2'b01, SUB, 32'h400, ALL1, 32'h404);
        chk("sub_lane_valid", 64'(out_lane_valid), 64'h1);
        chk("sub_aluop", 64'(out_ctrl[0].aluop), 64'(alu_sub));
        chk("sub_lane1_ctrl", 64'(out_ctrl[1]), 64'd0);
        chk("sub_lane1_illegal", 64'(out_illegal[1]), 64'd0);
        step();

        // Directed table through the scoreboard with intermittent backpressure
        for (int k = 0; k < 14; k++) begin
            out_ready = (k % 3 != 2);
            send((k % 4 == 3) ? 2'b01 : 2'b11, mk(tab[2*k][20:14], tab[2*k][13:11], tab[2*k][10:0]),
                 32'h1000 + 32'(8*k), mk(tab[2*k+1][20:14], tab[2*k+1][13:11], tab[2*k+1][10:0]),
                 32'h1004 + 32'(8*k));
        end
        out_ready = 1'b1;
        step(); step(); step();
        chk("table_drained", 64'(out_valid), 64'd0);

        // Flush in TWO with an incoming bundle
        out_ready = 1'b0;
        drive(2'b11, ADDI, 32'h500, SUB, 32'h504); step();
        drive(2'b11, SUB, 32'h508, ADDI, 32'h50C); step();
        chk("flush_pre_two", 64'(in_ready), 64'd0);
        drive(2'b01, ADDI, 32'h5F0, 32'h0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        step();
        chk("flush_dropped", 64'(out_valid), 64'd0);

        // Reset mid-stream
        drive(2'b11, ADDI, 32'h600, SUB, 32'h604); step();
        drive(2'b11, SUB, 32'h608, ADDI, 32'h60C); step();
        drive(2'b01, ADDI, 32'h6F0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("midrst");
        drive(2'b01, SUB, 32'h700, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_pc", 64'(out_pc[0]), 64'h700);
        out_ready = 1'b1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
